// File: rtl/adder_seq_ctrl_amisha.sv
// Nibble-serial wide adder: one 4-bit carry-chained slice reused over NIBBLES cycles,
// LSB nibble first, behind a start/done handshake.
module adder_seq_ctrl_amisha #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk_amisha,
    input  logic                 rst_n_amisha,
    input  logic                 start_amisha,
    input  logic [4*NIBBLES-1:0] a_amisha,
    input  logic [4*NIBBLES-1:0] b_amisha,
    input  logic                 cin_amisha,
    output logic                 busy_amisha,
    output logic                 done_amisha,
    output logic [4*NIBBLES-1:0] sum_amisha,
    output logic                 cout_amisha,
    output logic                 ovf_amisha
);

    localparam int unsigned W = 4 * NIBBLES;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0]   wsum_q, wsum_d;
    logic           c_q, c_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [3:0]     nib_a, nib_b;
    logic [4:0]     t;
    logic [W-1:0]   wsum_upd;
    logic           last_nib;

    // Nibble select and working-sum merge, written as constant-index muxes over cnt.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == 3'(i)) begin
                nib_a = opa_q[4*i +: 4];
                nib_b = opb_q[4*i +: 4];
            end
        end
        t = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, c_q};
        wsum_upd = wsum_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == 3'(i)) begin
                wsum_upd[4*i +: 4] = t[3:0];
            end
        end
        last_nib = (cnt_q == 3'(NIBBLES - 1));
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        wsum_d  = wsum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_amisha) begin
                    opa_d   = a_amisha;
                    opb_d   = b_amisha;
                    c_d     = cin_amisha;
                    cnt_d   = 3'd0;
                    wsum_d  = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                wsum_d = wsum_upd;
                c_d    = t[4];
                if (last_nib) begin
                    sum_d   = wsum_upd;
                    cout_d  = t[4];
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (wsum_upd[W-1] != opa_q[W-1]);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            wsum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= 3'd0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wsum_q  <= wsum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_amisha = (state_q == StRun);
    assign done_amisha = (state_q == StDone);
    assign sum_amisha  = sum_q;
    assign cout_amisha = cout_q;
    assign ovf_amisha  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl_amisha.sv
// Directed bench for adder_seq_ctrl_amisha: a 4-nibble and a 1-nibble instance on one clock.
module tb_adder_seq_ctrl_amisha;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        cin4 = 1'b0;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  sum1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_sum4 = '0;
    logic [3:0]  last_sum1 = '0;

    always #5 clk = ~clk;

    adder_seq_ctrl_amisha #(.NIBBLES(4)) dut4 (
        .clk_amisha   (clk),
        .rst_n_amisha (rst_n),
        .start_amisha (start4),
        .a_amisha     (a4),
        .b_amisha     (b4),
        .cin_amisha   (cin4),
        .busy_amisha  (busy4),
        .done_amisha  (done4),
        .sum_amisha   (sum4),
        .cout_amisha  (cout4),
        .ovf_amisha   (ovf4)
    );

    adder_seq_ctrl_amisha #(.NIBBLES(1)) dut1 (
        .clk_amisha   (clk),
        .rst_n_amisha (rst_n),
        .start_amisha (start1),
        .a_amisha     (a1),
        .b_amisha     (b1),
        .cin_amisha   (cin1),
        .busy_amisha  (busy1),
        .done_amisha  (done1),
        .sum_amisha   (sum1),
        .cout_amisha  (cout1),
        .ovf_amisha   (ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the 4-nibble instance; operands are scrambled right after accept.
    task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic eo, input bit mid);
        int lat;
        lat = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start4 = 1'b0; a4 = ~a; b4 = 16'h5A5A; cin4 = ~cin;
                check({tag, "_busy"}, {31'd0, busy4}, 32'd1);
                check({tag, "_held"}, {16'd0, sum4}, {16'd0, last_sum4});
            end
            if (mid && i == 2) begin
                start4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF;
            end
            if (mid && i == 3) start4 = 1'b0;
            if (done4) lat = i;
        end
        check({tag, "_lat"}, lat, 32'd5);
        check({tag, "_sum"}, {16'd0, sum4}, {16'd0, es});
        check({tag, "_cout_ovf"}, {30'd0, cout4, ovf4}, {30'd0, ec, eo});
        last_sum4 = es;
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, busy4, done4}, 32'd0);
    endtask

    task automatic run1(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic [3:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start1 = 1'b0; a1 = ~a; b1 = ~b;
                check({tag, "_busy"}, {31'd0, busy1}, 32'd1);
                check({tag, "_held"}, {28'd0, sum1}, {28'd0, last_sum1});
            end
            if (done1) lat = i;
        end
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_sum"}, {28'd0, sum1}, {28'd0, es});
        check({tag, "_cout_ovf"}, {30'd0, cout1, ovf1}, {30'd0, ec, eo});
        last_sum1 = es;
        @(negedge clk);
    endtask

    initial begin
        int dones;

        // Reset held for 3 edges, then idle with start low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out4", {12'd0, busy4, done4, cout4, ovf4, sum4}, 32'd0);
            check("rst_out1", {24'd0, busy1, done1, cout1, ovf1, sum1}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out4", {12'd0, busy4, done4, cout4, ovf4, sum4}, 32'd0);
        end

        run4("add_0_ffff", 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run4("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run4("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run4("ovf_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run4("cin_1234", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        run4("mid_start", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

        // start held high: done every 5 cycles, results back-to-back.
        dones = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = 16'h0001; b4 = 16'h0002; cin4 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done4) begin
                dones++;
                check("b2b_period", i, 5 * dones);
                check("b2b_sum", {16'd0, sum4}, 32'h0003);
            end
        end
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_count", dones, 32'd3);
        last_sum4 = 16'h0003;

        // Reset while RUN at cnt = 2.
        dones = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out", {12'd0, busy4, done4, cout4, ovf4, sum4}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check("midrst_nodone", dones, 32'd0);
        last_sum4 = 16'h0000;
        last_sum1 = 4'h0;
        run4("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        run1("n1_d_7", 4'hD, 4'h7, 1'b0, 4'h4, 1'b1, 1'b0);
        run1("n1_5_9", 4'h5, 4'h9, 1'b0, 4'hE, 1'b0, 1'b0);
        run1("n1_f_f", 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
